// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants and types for the instruction fetch unit.
//   XLEN     : default address / instruction width
//   RESET_PC : default fetch address after reset
//   NOP      : canonical no-operation instruction word
//   entry_t  : one instruction-buffer entry, {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Registered instruction buffer, DEPTH entries of WIDTH bits (DEPTH is a power
// of two). The head entry is presented on rdata; rdata reads as zero while the
// buffer is empty so the outputs are well defined out of reset.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   push, wdata   : write one entry (ignored when full)
//   pop           : discard the head entry (caller guarantees not empty)
//   flush         : empty the buffer; wins over push and pop
//   rdata         : head entry
//   full, empty   : occupancy flags
//   count         : number of entries held
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; = here would create ordering races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; its contents are only observable
  // through rdata, which is masked to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Sequential instruction fetcher with a credit-limited request stream, an
// in-order response path into a registered instruction buffer, and redirect
// (jump) handling that discards responses still in flight.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   jump, pc_imm    : redirect strobe and target (low two bits ignored)
//   mem_req_*       : request channel (valid/ready, word-aligned address)
//   mem_resp_*      : in-order read data, no back-pressure
//   instr_valid/ready, instr, pc_current : buffered instruction to decode
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int                   XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]      RESET_PC = XLEN'(fetch_pkg::RESET_PC),
  parameter int                   DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            jump,
  input  logic [XLEN-1:0] pc_imm,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc_current
);

  localparam int          CW        = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     outstanding_next;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       in_use;
  logic              req_fire;
  logic              resp_keep;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [2*XLEN-1:0] head;

  assign target       = {pc_imm[XLEN-1:2], 2'b00};
  assign mem_req_addr = fetch_pc;

  // Every issued request owns a buffer slot until it is consumed or dropped,
  // so the buffer can never overflow. Gated by reset so the request channel
  // is idle while the block is held in reset.
  assign in_use        = {1'b0, outstanding} + {1'b0, fifo_count};
  assign mem_req_valid = reset && !jump && (in_use < CREDIT_MAX);
  assign req_fire      = mem_req_valid && mem_req_ready;

  // A jump suppresses both buffer writes and buffer reads in its cycle.
  assign resp_keep   = mem_resp_valid && (drop_cnt == '0) && !jump;
  assign instr_valid = !fifo_empty;
  assign pop         = instr_valid && instr_ready && !jump;

  // Requests and responses are counted even in a jump cycle, so the drop
  // count loaded on a jump already excludes a response arriving with it.
  // NOTE: outstanding_next gets a default before any conditional update so
  // this always_comb can never infer a latch.
  always_comb begin
    outstanding_next = outstanding;
    if (req_fire)       outstanding_next = outstanding_next + 1'b1;
    if (mem_resp_valid) outstanding_next = outstanding_next - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (jump) begin
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= outstanding_next;
      end else begin
        if (req_fire)  fetch_pc <= fetch_pc + XLEN'(4);
        if (resp_keep) resp_pc  <= resp_pc + XLEN'(4);
        if (mem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    // The credit rule already prevents writes to a full buffer; the extra
    // term only keeps the pointers coherent if memory misbehaves.
    .push  (resp_keep && !fifo_full),
    .pop   (pop),
    .flush (jump),
    .wdata ({resp_pc, mem_resp_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign pc_current = head[2*XLEN-1:XLEN];
  assign instr      = head[XLEN-1:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32: address and instruction width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-003 Parameter DEPTH, default 4, power of two, at least 2: instruction buffer entries, which is also the maximum number of requests in flight.
REQ-004 Ports, in order:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- jump  in  1  redirect strobe.
- pc_imm  in  XLEN  redirect target.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  XLEN  word-aligned fetch address.
- mem_resp_valid  in  1  read data returned, in request order.
- mem_resp_data  in  XLEN  returned instruction word.
- instr_valid  out  1  instr and pc_current are valid.
- instr_ready  in  1  decode consumes the instruction.
- instr  out  XLEN  buffered instruction.
- pc_current  out  XLEN  address of instr.

Function
REQ-005 The block SHALL keep fetch_pc, the next address to request, and SHALL drive mem_req_addr = fetch_pc.
REQ-006 The block SHALL assert mem_req_valid when (outstanding + fifo_count) < DEPTH and jump = 0.
REQ-007 On mem_req_valid && mem_req_ready, the block SHALL increment outstanding and set fetch_pc to fetch_pc + 4, wrapping modulo 2^XLEN.
REQ-008 On mem_resp_valid with drop_cnt = 0, the block SHALL push {resp_pc, mem_resp_data} into the buffer, decrement outstanding, and advance resp_pc by 4.
REQ-009 On mem_resp_valid with drop_cnt > 0, the block SHALL discard the data and decrement both drop_cnt and outstanding.
REQ-010 instr_valid SHALL equal "buffer not empty"; instr and pc_current SHALL show the buffer head.
REQ-011 On instr_valid && instr_ready, the block SHALL pop the head; a push and a pop in the same cycle SHALL leave fifo_count unchanged.
REQ-012 The block SHALL not assert mem_resp_valid-driven overflow: the credit rule in REQ-006 guarantees a push is never made to a full buffer.
REQ-013 On jump = 1, at the next edge the block SHALL:
- set fetch_pc and resp_pc to {pc_imm[XLEN-1:2], 2'b00};
- empty the buffer;
- set drop_cnt to the outstanding count after this cycle's response, if any, has been counted.
REQ-014 jump SHALL take priority over a simultaneous push, pop or response; a response arriving in the jump cycle SHALL be counted against outstanding and SHALL never enter the buffer.
REQ-015 instr_valid SHALL be 0 in the cycle after a jump.
REQ-016 The first post-jump instruction SHALL appear no earlier than 2 cycles after the jump.
REQ-017 Fetch-to-instr_valid latency SHALL be memory latency + 1 cycle, because the buffer is registered.
REQ-018 The pc_current/instr pairing SHALL stay correct under any mix of back-pressure on mem_req_ready and on instr_ready.

Reset
REQ-019 While reset = 0, asynchronously:
- fetch_pc and resp_pc = RESET_PC;
- outstanding, drop_cnt and fifo_count = 0;
- instr and pc_current = 0;
- instr_valid and mem_req_valid = 0.
REQ-020 After reset deassertion, the first request SHALL be issued at the first rising edge with address RESET_PC.
REQ-021 A reset applied mid-operation SHALL abandon all in-flight requests; the memory model is reset together with the block.

Structure
REQ-022 Package fetch_pkg SHALL hold XLEN, RESET_PC, the instruction NOP constant 32'h0000_0013, and the {pc, instr} entry struct typedef.
REQ-023 The buffer SHALL be a separate sub-module, fetch_fifo, parametrised by width and DEPTH, with push, pop, flush, full, empty and count ports.
REQ-024 The outstanding and drop_cnt counters SHALL be $clog2(DEPTH)+1 bits wide.

Verification
REQ-025 Reset release with 1-cycle memory and instr_ready = 1 -> instructions appear at pc_current 0, 4, 8, 12, each with its matching data.
REQ-026 Hold instr_ready = 0 with DEPTH = 4 -> exactly 4 requests issued, then mem_req_valid = 0; one pop -> one new request.
REQ-027 jump with pc_imm = 32'h0000_0102 while 3 requests are outstanding -> 3 responses dropped; the next instr has pc_current = 32'h0000_0100; no stale instruction is seen.
REQ-028 jump in the same cycle as mem_resp_valid and a pop -> buffer empty, that response not delivered, the next fetch address is the target.
REQ-029 Random mem_req_ready and instr_ready plus random memory latency, 10k cycles, with the scoreboard checking pc_current + 4 sequencing between jumps -> zero mismatches.
REQ-030 Assert reset with 2 requests outstanding -> all outputs at their reset values immediately; the first request after release goes to RESET_PC.
